// File: rtl/mips_main_control_fsm.sv
// Multicycle MIPS main controller: Moore FSM stepping each instruction through
// fetch, decode and opcode-specific execute/memory/writeback states.
// Ports: clk, reset (async, active-high) and Op (IR[31:26]) in; datapath
// enables/mux selects, the 2-bit ALUOp and the debug State code out.
module mips_main_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       Branch,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic. Op is only consulted in DECODE and MEMADR, where the
    // instruction register is guaranteed stable.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYP:      state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    // Unknown opcode: PC already advanced, so simply skip it.
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (Op == OP_LW)      state_d = MEMRD;
                else if (Op == OP_SW) state_d = MEMWR;
                else                  state_d = FETCH;
            end
            MEMRD:    state_d = MEMWB;
            EXECUTE:  state_d = ALUWB;
            ADDIEXEC: state_d = ADDIWB;
            // Terminal states and illegal codes 12-15 all return to FETCH.
            default:  state_d = FETCH;
        endcase
    end

    // Moore output decode; everything defaults to 0 so illegal codes are quiet.
    always_comb begin
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSrc    = 2'b00;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            // Precompute the branch target PC+4+(SignImm<<2) while decoding.
            DECODE:   ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD:    IorD = 1'b1;
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
            end
            ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB:   RegWrite = 1'b1;
            JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Bench for mips_main_control_fsm: table of per-opcode state sequences with a
// scoreboard queue of expected {State, controls}, plus hand-written sequences
// for reset, an opcode change in MEMADR and an asynchronous mid-lw reset.
module tb_mips_main_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCWrite, Branch;
    logic [3:0] State;

    mips_main_control_fsm dut (
        .clk(clk), .reset(reset), .Op(Op),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite),
        .Branch(Branch), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctl_t;

    typedef struct packed {
        logic [3:0] state;
        ctl_t       ctl;
    } obs_t;

    typedef struct {
        string           name;
        logic [5:0]      op;
        int              len;
        logic [4:0][3:0] seq;   // seq[0] is the first state visited
    } vec_t;

    int   n_vec  = 0;
    int   n_fail = 0;
    obs_t sb_q[$];

    // Reference control values per state, written straight from the state table.
    function automatic ctl_t ref_ctl(input logic [3:0] s);
        ctl_t c;
        c = '0;
        case (s)
            4'd0:  begin c.irwrite = 1; c.pcwrite = 1; c.alusrcb = 2'b01; end
            4'd1:  c.alusrcb = 2'b11;
            4'd2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            4'd3:  c.iord = 1;
            4'd4:  begin c.regwrite = 1; c.memtoreg = 1; end
            4'd5:  begin c.iord = 1; c.memwrite = 1; end
            4'd6:  begin c.alusrca = 1; c.aluop = 2'b10; end
            4'd7:  begin c.regwrite = 1; c.regdst = 1; end
            4'd8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1; end
            4'd9:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            4'd10: c.regwrite = 1;
            4'd11: begin c.pcsrc = 2'b10; c.pcwrite = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.state = State;
        o.ctl   = '{IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                    ALUSrcB, ALUOp, PCSrc, PCWrite, Branch};
        return o;
    endfunction

    task automatic push_exp(input logic [3:0] s);
        obs_t e;
        e.state = s;
        e.ctl   = ref_ctl(s);
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string name);
        obs_t e, a;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got state %0d", name, State);
            return;
        end
        e = sb_q.pop_front();
        a = observe();
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                     name, a.state, a.ctl, e.state, e.ctl);
        end
    endtask

    vec_t vecs[8];
    logic regwrite_seen;
    logic watch_rw = 1'b0;

    always @(posedge RegWrite or posedge watch_rw)
        if (watch_rw && RegWrite === 1'b1) regwrite_seen = 1'b1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"lw",     6'b100011, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};
        vecs[1] = '{"sw",     6'b101011, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}};
        vecs[2] = '{"rtype",  6'b000000, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
        vecs[3] = '{"beq",    6'b000100, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
        vecs[4] = '{"addi",   6'b001000, 4, {4'd0, 4'd10, 4'd9, 4'd1, 4'd0}};
        vecs[5] = '{"j",      6'b000010, 3, {4'd0, 4'd0, 4'd11, 4'd1, 4'd0}};
        vecs[6] = '{"bad3f",  6'b111111, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};
        vecs[7] = '{"bad03",  6'b000011, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};

        // Reset held for 3 cycles: FETCH decode throughout.
        reset = 1'b1;
        Op    = 6'b000000;
        #1;
        for (int i = 0; i < 3; i++) begin
            push_exp(4'd0);
            pop_check("reset_hold");
            @(negedge clk);
        end
        reset = 1'b0;

        // Table-driven instructions, each starting and ending in FETCH.
        for (int v = 0; v < 8; v++) begin
            Op = vecs[v].op;
            for (int k = 0; k < vecs[v].len; k++) push_exp(vecs[v].seq[k]);
            for (int k = 0; k < vecs[v].len; k++) begin
                pop_check(vecs[v].name);
                @(negedge clk);
            end
        end
        push_exp(4'd0);
        pop_check("back_to_fetch");

        // Opcode changes to non-memory while in MEMADR: must fall back to FETCH.
        Op = 6'b100011;
        push_exp(4'd0); push_exp(4'd1); push_exp(4'd2); push_exp(4'd0);
        pop_check("memadr_other"); @(negedge clk);
        pop_check("memadr_other"); @(negedge clk);
        Op = 6'b000000;
        pop_check("memadr_other"); @(negedge clk);
        pop_check("memadr_other");

        // Asynchronous reset during MEMRD of lw: no RegWrite pulse afterwards.
        Op = 6'b100011;
        regwrite_seen = 1'b0;
        push_exp(4'd0); push_exp(4'd1); push_exp(4'd2); push_exp(4'd3);
        pop_check("lw_abort"); @(negedge clk);
        pop_check("lw_abort"); @(negedge clk);
        pop_check("lw_abort"); @(negedge clk);
        pop_check("lw_abort");
        watch_rw = 1'b1;
        #2 reset = 1'b1;
        #1;
        push_exp(4'd0);
        pop_check("async_reset");      // before any clock edge
        @(negedge clk);
        reset = 1'b0;
        Op = 6'b000010;
        push_exp(4'd0); push_exp(4'd1); push_exp(4'd11); push_exp(4'd0);
        for (int k = 0; k < 4; k++) begin
            pop_check("after_abort");
            if (k < 3) @(negedge clk);
        end
        watch_rw = 1'b0;
        n_vec++;
        if (regwrite_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL no_regwrite_after_abort: got RegWrite pulse=%b, expected 0",
                     regwrite_seen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_main_control_fsm.md
# mips_main_control_fsm

Multicycle main controller for the MIPS control unit. A Moore state machine steps each instruction through fetch, decode and the opcode-specific execute, memory and writeback states. It drives all datapath enables and muxes, and produces the 2-bit `ALUOp` that the ALU decoder turns into `ALUControl`. It sits beside the ALU decoder inside the control unit; its inputs are `Op` from the instruction register and its outputs go to the datapath.

## Interface
- No parameters.
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high; forces state to FETCH
- `Op`  in  6  opcode, instruction register [31:26]
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemWrite`  out  1  data memory write strobe
- `IRWrite`  out  1  instruction register load enable
- `RegDst`  out  1  register write address: 0 = rt, 1 = rd
- `MemtoReg`  out  1  register write data: 0 = ALUOut, 1 = Data
- `RegWrite`  out  1  register file write enable
- `ALUSrcA`  out  1  ALU A: 0 = PC, 1 = A register
- `ALUSrcB`  out  2  ALU B: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- `ALUOp`  out  2  to ALU decoder: 00 = add, 01 = subtract, 10 = use funct
- `PCSrc`  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- `PCWrite`  out  1  unconditional PC write
- `Branch`  out  1  conditional PC write; datapath ANDs it with Zero
- `State`  out  4  current state encoding, for debug and verification

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12–15 are illegal and go to FETCH on the next edge.
- Opcodes: lw=100011, sw=101011, R-type=000000, beq=000100, addi=001000, j=000010.
- State transitions:
  - FETCH→DECODE.
  - DECODE branches on `Op`:
    - lw/sw → MEMADR
    - R-type → EXECUTE
    - beq → BRANCH
    - addi → ADDIEXEC
    - j → JUMP
    - any other opcode → FETCH (instruction skipped; PC already advanced in FETCH)
  - MEMADR: lw → MEMRD, sw → MEMWR, otherwise FETCH.
  - MEMRD→MEMWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP → FETCH.
  - EXECUTE→ALUWB.
  - ADDIEXEC→ADDIWB.
- Outputs are pure combinational decode of state. Every signal not listed below is 0 in that state.
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01 (ALUOp=00, PCSrc=00, IorD=0, ALUSrcA=0).
  - DECODE: ALUSrcB=11 (ALUOp=00), precomputing the branch target.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1 (RegDst=0).
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10 (ALUSrcB=00).
  - ALUWB: RegWrite=1, RegDst=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10.
  - ADDIWB: RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
  - Illegal codes: all outputs 0.
- No output ever takes X. `ALUOp`=11 is never driven.

## Timing
- The state register updates on the rising edge of `clk`. `reset` clears it to FETCH immediately, with no clock required.
- Reset values of outputs are the FETCH decode: IRWrite=1, PCWrite=1, ALUSrcB=01, `State`=0, everything else 0. Datapath registers are held in their own reset, so these strobes have no effect while reset is asserted.
- After reset deasserts, the first rising edge executes FETCH and moves to DECODE.
- `Op` is sampled only in DECODE and MEMADR. It is stable then because IRWrite is 0 outside FETCH.
- Instruction latency in cycles, FETCH entry to next FETCH entry:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - unknown opcode: 2
- Reset asserted mid-instruction aborts immediately. No partial writeback is issued after the asynchronous clear.

## Test plan
- Reset held for 3 cycles, then released → `State`=0 during reset, with IRWrite=1, PCWrite=1, ALUSrcB=01. The first edge after release gives `State`=1.
- `Op`=100011 (lw) → `State` sequence 0,1,2,3,4,0. MEMRD has IorD=1. MEMWB has RegWrite=1 and MemtoReg=1.
- `Op`=101011 (sw) → sequence 0,1,2,5,0. MemWrite=1 and IorD=1 only in state 5. RegWrite is never 1.
- `Op`=000000 (R-type) → sequence 0,1,6,7,0. ALUOp=10 in state 6. State 7 has RegWrite=1 and RegDst=1.
- `Op`=000100 (beq), then 001000 (addi), then 000010 (j) → state sequences:
  - beq: 0,1,8,0, with ALUOp=01, Branch=1, PCSrc=01 in state 8
  - addi: 0,1,9,10,0
  - j: 0,1,11,0, with PCSrc=10 and PCWrite=1 in state 11
- `Op`=111111 in DECODE → returns to `State`=0 next cycle. Separately, asserting reset during MEMRD of an lw → `State`=0 asynchronously, and RegWrite never pulses.
